// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-master UART register-port arbiter.
package uart_arb_pkg;

   // Width of the BUSY stall counter.
   localparam int CNT_W = 16;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      RDATA = 2'd2
   } arb_state_e;

   // One-hot grant encodings; bit 0 is m0, bit 1 is m1.
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/uart_arb_rr.sv
// Combinational 2-way picker: lock owner first, then the priority pointer,
// then whichever master is left.
module uart_arb_rr
   import uart_arb_pkg::*;
(
   input  logic [1:0] req_i,         // {m1_stb, m0_stb}
   input  logic       ptr_i,         // 0 = m0 favoured, 1 = m1 favoured
   input  logic [1:0] lock_owner_i,  // one-hot master holding the lock, or 00
   output logic [1:0] win_o          // one-hot winner, 00 when nobody requests
);

   logic [1:0] locked_req;

   assign locked_req = lock_owner_i & req_i;

   // Pick the winner in strict precedence order.
   always_comb begin
      win_o = GNT_NONE;
      if (locked_req != GNT_NONE) begin
         win_o = locked_req;
      end else if (req_i[ptr_i]) begin
         win_o = ptr_i ? GNT_M1 : GNT_M0;
      end else if (req_i[!ptr_i]) begin
         win_o = ptr_i ? GNT_M0 : GNT_M1;
      end
   end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the single UART register port between the CPU (m0) and the
// boot/debug loader (m1): round-robin grant, per-master lock, registered
// read-data return and a stall timeout that reports err.
//
// Handshake: a master raises stb with we/adr/dat (and lock) stable and holds
// them until it sees a one-cycle ack or err. Writes complete in the cycle the
// slave acks; reads complete one cycle later, when the slave's registered
// data is returned with ack. Dropping stb before completion aborts silently.
module uart_bus_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 65535,
   parameter bit          M0_FIRST = 1'b1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic        m0_lock_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_lock_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);

   // Last stall cycle before the access is abandoned.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state_q;
   logic [1:0]       gnt_q;
   logic             ptr_q;
   logic [1:0]       lock_q;
   logic [CNT_W-1:0] cnt_q;

   logic [1:0]  req;
   logic [1:0]  win;
   logic        g_stb;
   logic        g_we;
   logic [31:0] g_adr;
   logic [31:0] g_dat;
   logic        g_lock;
   logic        busy;
   logic        abort;
   logic        wr_done;
   logic        rd_go;
   logic        rd_done;
   logic        tmo;

   assign req = {m1_stb_i, m0_stb_i};

   uart_arb_rr u_rr (
      .req_i        (req),
      .ptr_i        (ptr_q),
      .lock_owner_i (lock_q),
      .win_o        (win)
   );

   // Route the granted master's request fields; all zero with no grant.
   always_comb begin
      g_stb  = 1'b0;
      g_we   = 1'b0;
      g_adr  = '0;
      g_dat  = '0;
      g_lock = 1'b0;
      case (gnt_q)
         GNT_M0: begin
            g_stb  = m0_stb_i;
            g_we   = m0_we_i;
            g_adr  = m0_adr_i;
            g_dat  = m0_dat_i;
            g_lock = m0_lock_i;
         end
         GNT_M1: begin
            g_stb  = m1_stb_i;
            g_we   = m1_we_i;
            g_adr  = m1_adr_i;
            g_dat  = m1_dat_i;
            g_lock = m1_lock_i;
         end
         default: ;
      endcase
   end

   assign busy    = (state_q == BUSY);
   assign abort   = busy & ~g_stb;
   assign wr_done = busy & g_stb & s_ack_i & g_we;
   assign rd_go   = busy & g_stb & s_ack_i & ~g_we;
   assign tmo     = busy & g_stb & ~s_ack_i & (cnt_q == TMO_LAST);
   assign rd_done = (state_q == RDATA);

   // The slave strobe is only live in BUSY, so a read pops the FIFO once.
   assign s_stb_o = busy & g_stb;
   assign s_we_o  = g_we;
   assign s_adr_o = g_adr;
   assign s_dat_o = g_dat;
   assign gnt_o   = gnt_q;

   // Completion pulses reach only the granted master.
   assign m0_ack_o = gnt_q[0] & (wr_done | rd_done);
   assign m1_ack_o = gnt_q[1] & (wr_done | rd_done);
   assign m0_err_o = gnt_q[0] & tmo;
   assign m1_err_o = gnt_q[1] & tmo;
   assign m0_dat_o = (gnt_q[0] & rd_done) ? s_dat_i : '0;
   assign m1_dat_o = (gnt_q[1] & rd_done) ? s_dat_i : '0;

   // Access sequencer: arbitrate, track the stall count and update the
   // lock/pointer bookkeeping on each completion.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         gnt_q   <= GNT_NONE;
         ptr_q   <= M0_FIRST ? 1'b0 : 1'b1;
         lock_q  <= GNT_NONE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               // A lock owner that is not asking gives its lock up.
               if ((lock_q & req) == GNT_NONE) begin
                  lock_q <= GNT_NONE;
               end
               if (win != GNT_NONE) begin
                  gnt_q   <= win;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (abort) begin
                  state_q <= IDLE;
                  gnt_q   <= GNT_NONE;
                  cnt_q   <= '0;
               end else if (wr_done || tmo) begin
                  state_q <= IDLE;
                  gnt_q   <= GNT_NONE;
                  cnt_q   <= '0;
                  lock_q  <= g_lock ? gnt_q : GNT_NONE;
                  if (!g_lock) begin
                     ptr_q <= gnt_q[0];
                  end
               end else if (rd_go) begin
                  state_q <= RDATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RDATA: begin
               state_q <= IDLE;
               gnt_q   <= GNT_NONE;
               cnt_q   <= '0;
               lock_q  <= g_lock ? gnt_q : GNT_NONE;
               if (!g_lock) begin
                  ptr_q <= gnt_q[0];
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= GNT_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a small UART slave model.
module tb_uart_bus_arbiter;

   localparam int TMO = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        m0_stb_i = 1'b0, m0_we_i = 1'b0, m0_lock_i = 1'b0;
   logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
   logic        m1_stb_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
   logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
   logic        s_stb_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [31:0] s_dat_i = '0;
   logic        s_ack_i;
   logic [1:0]  gnt_o;

   logic        s_ack_en = 1'b1;
   int          stb_cycles = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   uart_bus_arbiter #(.TIMEOUT(TMO), .M0_FIRST(1'b1)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .m0_stb_i (m0_stb_i),
      .m0_we_i  (m0_we_i),
      .m0_adr_i (m0_adr_i),
      .m0_dat_i (m0_dat_i),
      .m0_lock_i(m0_lock_i),
      .m0_dat_o (m0_dat_o),
      .m0_ack_o (m0_ack_o),
      .m0_err_o (m0_err_o),
      .m1_stb_i (m1_stb_i),
      .m1_we_i  (m1_we_i),
      .m1_adr_i (m1_adr_i),
      .m1_dat_i (m1_dat_i),
      .m1_lock_i(m1_lock_i),
      .m1_dat_o (m1_dat_o),
      .m1_ack_o (m1_ack_o),
      .m1_err_o (m1_err_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_dat_i  (s_dat_i),
      .s_ack_i  (s_ack_i),
      .gnt_o    (gnt_o)
   );

   // Clock
   always #5 sys_clk = ~sys_clk;

   // Slave model: combinational ack, read data registered one cycle later.
   function automatic logic [31:0] rd_data(input logic [31:0] adr);
      return (adr == 32'd1) ? 32'h0000_0036 : {16'hD00D, adr[15:0]};
   endfunction

   assign s_ack_i = s_stb_o & s_ack_en;

   always @(posedge sys_clk) begin
      s_dat_i <= (s_stb_o && s_ack_i && !s_we_o) ? rd_data(s_adr_o) : 32'h0;
      if (s_stb_o) stb_cycles <= stb_cycles + 1;
   end

   // Drivers
   task automatic set_m0(input logic stb, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic lock);
      m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_lock_i = lock;
   endtask

   task automatic set_m1(input logic stb, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic lock);
      m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_lock_i = lock;
   endtask

   task automatic test_reset();
      logic [135:0] outs;
      set_m0(1'b1, 1'b1, 32'h0, 32'h41, 1'b0);
      @(negedge sys_clk); @(negedge sys_clk); #1;
      outs = {gnt_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o,
              m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
      n_checks++; if (outs !== '0) begin n_errors++; $display("FAIL reset_outputs got %h want 0", outs); end
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge sys_clk); sys_rst = 1'b0; #1;
      @(negedge sys_clk); #1;
      n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL reset_idle_gnt got %b want 00", gnt_o); end
   endtask

   task automatic test_single_write();
      @(negedge sys_clk); set_m0(1'b1, 1'b1, 32'h0, 32'h41, 1'b0); #1;
      n_checks++; if ({gnt_o, s_stb_o} !== 3'b000) begin n_errors++; $display("FAIL wr_c0 got %b want 000", {gnt_o, s_stb_o}); end
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o} !== 7'b01_1_1_1_0_0) begin
         n_errors++; $display("FAIL wr_c1 got %b want 0111100", {gnt_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o}); end
      n_checks++; if ({s_adr_o, s_dat_o} !== {32'h0, 32'h41}) begin
         n_errors++; $display("FAIL wr_fwd got %h want %h", {s_adr_o, s_dat_o}, {32'h0, 32'h41}); end
      @(negedge sys_clk); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #1;
      n_checks++; if ({gnt_o, s_stb_o, m0_ack_o} !== 4'b0000) begin n_errors++; $display("FAIL wr_c2 got %b want 0000", {gnt_o, s_stb_o, m0_ack_o}); end
   endtask

   // Both masters issue four writes; pointer already favours m1.
   task automatic test_alternate();
      logic [1:0]  exp_q[$];
      logic [31:0] want;
      int n0, n1;
      exp_q = {2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      n0 = 0; n1 = 0;
      @(negedge sys_clk);
      set_m0(1'b1, 1'b1, 32'h10, 32'h100, 1'b0);
      set_m1(1'b1, 1'b1, 32'h20, 32'h200, 1'b0);
      #1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         if (m0_ack_o || m1_ack_o) begin
            n_checks++; if ({m1_ack_o, m0_ack_o} !== exp_q[0]) begin n_errors++; $display("FAIL alt_order got %b want %b", {m1_ack_o, m0_ack_o}, exp_q[0]); end
            n_checks++; if (gnt_o !== exp_q[0]) begin n_errors++; $display("FAIL alt_gnt got %b want %b", gnt_o, exp_q[0]); end
            want = m0_ack_o ? 32'(32'h100 + n0) : 32'(32'h200 + n1);
            n_checks++; if (s_dat_o !== want) begin n_errors++; $display("FAIL alt_wdata got %h want %h", s_dat_o, want); end
            if (m0_ack_o) n0++; else n1++;
            void'(exp_q.pop_front());
         end
         @(negedge sys_clk);
         set_m0(n0 < 4, 1'b1, 32'h10, 32'(32'h100 + n0), 1'b0);
         set_m1(n1 < 4, 1'b1, 32'h20, 32'(32'h200 + n1), 1'b0);
         #1;
      end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL alt_timeout got %0d left want 0", exp_q.size()); end
      @(negedge sys_clk);
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_read();
      int stb0;
      @(negedge sys_clk); stb0 = stb_cycles; set_m1(1'b1, 1'b0, 32'h1, 32'h0, 1'b0); #1;
      n_checks++; if ({gnt_o, m1_ack_o} !== 3'b000) begin n_errors++; $display("FAIL rd_c0 got %b want 000", {gnt_o, m1_ack_o}); end
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, s_stb_o, s_we_o, m1_ack_o} !== 5'b10_1_0_0) begin n_errors++; $display("FAIL rd_c1 got %b want 10100", {gnt_o, s_stb_o, s_we_o, m1_ack_o}); end
      n_checks++; if (s_adr_o !== 32'h1) begin n_errors++; $display("FAIL rd_adr got %h want 1", s_adr_o); end
      @(negedge sys_clk); #1;
      n_checks++; if ({m1_ack_o, s_stb_o, m0_ack_o} !== 3'b100) begin n_errors++; $display("FAIL rd_c2 got %b want 100", {m1_ack_o, s_stb_o, m0_ack_o}); end
      n_checks++; if (m1_dat_o !== 32'h36) begin n_errors++; $display("FAIL rd_data got %h want 36", m1_dat_o); end
      n_checks++; if (m0_dat_o !== 32'h0) begin n_errors++; $display("FAIL rd_other_dat got %h want 0", m0_dat_o); end
      @(negedge sys_clk); set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #1;
      n_checks++; if ({gnt_o, m1_ack_o, m1_dat_o} !== 35'h0) begin n_errors++; $display("FAIL rd_c3 got %h want 0", {gnt_o, m1_ack_o, m1_dat_o}); end
      n_checks++; if (stb_cycles - stb0 != 1) begin n_errors++; $display("FAIL rd_strobes got %0d want 1", stb_cycles - stb0); end
   endtask

   // m1 reads with lock 1,1,0,0; m0 asks for one write from m1's first ack on.
   task automatic test_lock();
      logic [1:0]  exp_q[$];
      logic [31:0] want;
      int n0, n1;
      exp_q = {2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
      n0 = 0; n1 = 0;
      @(negedge sys_clk);
      set_m1(1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
      #1;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         if (m0_ack_o || m1_ack_o) begin
            n_checks++; if ({m1_ack_o, m0_ack_o} !== exp_q[0]) begin n_errors++; $display("FAIL lock_order got %b want %b", {m1_ack_o, m0_ack_o}, exp_q[0]); end
            if (m1_ack_o) begin
               want = {16'hD00D, 16'(4 + n1)};
               n_checks++; if (m1_dat_o !== want) begin n_errors++; $display("FAIL lock_rdata got %h want %h", m1_dat_o, want); end
               n1++;
            end else begin
               n_checks++; if (s_dat_o !== 32'h55) begin n_errors++; $display("FAIL lock_wdata got %h want 55", s_dat_o); end
               n0++;
            end
            void'(exp_q.pop_front());
         end
         @(negedge sys_clk);
         set_m1(n1 < 4, 1'b0, 32'(4 + n1), 32'h0, n1 < 2);
         set_m0(n1 >= 1 && n0 < 1, 1'b1, 32'h3, 32'h55, 1'b0);
         #1;
      end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL lock_timeout got %0d left want 0", exp_q.size()); end
      @(negedge sys_clk);
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_timeout(input int who);
      logic [1:0] exp_err;
      exp_err = (who == 0) ? 2'b01 : 2'b10;
      s_ack_en = 1'b0;
      @(negedge sys_clk);
      if (who == 0) set_m0(1'b1, 1'b1, 32'h5, 32'h77, 1'b0);
      else          set_m1(1'b1, 1'b1, 32'h5, 32'h77, 1'b0);
      #1;
      for (int c = 1; c <= TMO; c++) begin
         @(negedge sys_clk); #1;
         if (c < TMO) begin
            n_checks++; if ({s_stb_o, m1_err_o, m0_err_o, m1_ack_o, m0_ack_o} !== 5'b10000) begin
               n_errors++; $display("FAIL tmo_early cyc %0d got %b want 10000", c, {s_stb_o, m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}); end
         end else begin
            n_checks++; if ({m1_err_o, m0_err_o, m1_ack_o, m0_ack_o} !== {exp_err, 2'b00}) begin
               n_errors++; $display("FAIL tmo_err got %b want %b", {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, {exp_err, 2'b00}); end
         end
      end
      @(negedge sys_clk);
      set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      n_checks++; if ({gnt_o, m1_err_o, m0_err_o} !== 4'b0000) begin n_errors++; $display("FAIL tmo_after got %b want 0000", {gnt_o, m1_err_o, m0_err_o}); end
      s_ack_en = 1'b1;
   endtask

   task automatic test_abort();
      s_ack_en = 1'b0;
      @(negedge sys_clk); set_m1(1'b1, 1'b1, 32'h7, 32'h99, 1'b0); #1;
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, s_stb_o} !== 3'b101) begin n_errors++; $display("FAIL abort_busy got %b want 101", {gnt_o, s_stb_o}); end
      @(negedge sys_clk); set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #1;
      n_checks++; if ({s_stb_o, m1_ack_o, m1_err_o} !== 3'b000) begin n_errors++; $display("FAIL abort_drop got %b want 000", {s_stb_o, m1_ack_o, m1_err_o}); end
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, m1_ack_o, m1_err_o} !== 4'b0000) begin n_errors++; $display("FAIL abort_idle got %b want 0000", {gnt_o, m1_ack_o, m1_err_o}); end
      s_ack_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [135:0] outs;
      s_ack_en = 1'b0;
      @(negedge sys_clk); set_m0(1'b1, 1'b1, 32'h9, 32'hAB, 1'b0); #1;
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, s_stb_o} !== 3'b011) begin n_errors++; $display("FAIL rstmid_busy got %b want 011", {gnt_o, s_stb_o}); end
      @(negedge sys_clk); sys_rst = 1'b1; s_ack_en = 1'b1; set_m1(1'b1, 1'b1, 32'hA, 32'hCD, 1'b0); #1;
      outs = {gnt_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o,
              m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
      n_checks++; if (outs !== '0) begin n_errors++; $display("FAIL rstmid_outputs got %h want 0", outs); end
      @(negedge sys_clk); sys_rst = 1'b0; #1;
      n_checks++; if ({gnt_o, s_stb_o} !== 3'b000) begin n_errors++; $display("FAIL rstmid_r0 got %b want 000", {gnt_o, s_stb_o}); end
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b0110) begin n_errors++; $display("FAIL rstmid_r1 got %b want 0110", {gnt_o, m0_ack_o, m1_ack_o}); end
      @(negedge sys_clk); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #1;
      n_checks++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b0000) begin n_errors++; $display("FAIL rstmid_r2 got %b want 0000", {gnt_o, m0_ack_o, m1_ack_o}); end
      @(negedge sys_clk); #1;
      n_checks++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b1001) begin n_errors++; $display("FAIL rstmid_r3 got %b want 1001", {gnt_o, m0_ack_o, m1_ack_o}); end
      @(negedge sys_clk); set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #1;
      n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL rstmid_r4 got %b want 00", gnt_o); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_alternate();
      test_read();
      test_lock();
      test_timeout(0);
      test_timeout(1);
      test_abort();
      test_reset_mid();
      repeat (2) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound for the whole run.
   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Two-master arbiter that shares the single UART register port (32-bit data/address, stb/we/ack, registered read data) between the CPU (m0) and a boot/debug loader (m1).
- Sits between the two bus masters and the UART slave.
- Provides round-robin grant, a per-master lock for back-to-back sequences, read-data return timing, and a stall timeout that reports an error.

Parameters:
- TIMEOUT, 65535, cycles in BUSY without slave ack before the access is aborted with err (16-bit counter).
- M0_FIRST, 1, priority pointer after reset favours m0 (1) or m1 (0).

Ports:
- sys_clk  input  1  clock
- sys_rst  input  1  asynchronous, active-high reset
- m0_stb_i, m1_stb_i  input  1  access request; held until ack or err
- m0_we_i, m1_we_i  input  1  1 = write, 0 = read
- m0_adr_i, m1_adr_i  input  32  register address
- m0_dat_i, m1_dat_i  input  32  write data
- m0_lock_i, m1_lock_i  input  1  keep grant for the next access
- m0_dat_o, m1_dat_o  output  32  read data; valid only with ack
- m0_ack_o, m1_ack_o  output  1  one-cycle completion pulse
- m0_err_o, m1_err_o  output  1  one-cycle timeout pulse
- s_stb_o  output  1  request to UART
- s_we_o  output  1  forwarded we
- s_adr_o  output  32  forwarded address
- s_dat_o  output  32  forwarded write data
- s_dat_i  input  32  UART read data, valid the cycle after s_ack_i
- s_ack_i  input  1  UART ack (combinational in the slave; low on a write while the TX FIFO is full)
- gnt_o  output  2  one-hot current grant; 00 when idle

Behaviour:
- States: IDLE, BUSY, RDATA. Grant register (gnt), priority pointer (ptr), timeout counter (cnt).
- Reset value of every output is 0. On reset: state=IDLE, gnt=00, cnt=0, ptr=M0_FIRST?m0:m1. Reset mid-access drops s_stb_o immediately, with no ack or err.

IDLE:
- Arbitrate among stb requests:
  - a locked master (lock flag set at its last completion) wins if its stb is high;
  - otherwise the ptr master wins if requesting;
  - otherwise the other master wins.
- Winner → gnt registered, state BUSY next cycle. No request → stay.

BUSY:
- s_stb_o = granted stb; s_we/adr/dat_o muxed from the granted master (all 0 when gnt=00).
- cnt increments each cycle that s_ack_i is low.
- Write with s_ack_i=1: granted m_ack_o=1 in the same cycle (combinational pass-through) → IDLE.
- Read with s_ack_i=1: → RDATA. s_stb_o deasserts in RDATA, which ensures a single slave read strobe and a single FIFO pop.
- cnt reaches TIMEOUT-1 with no ack: granted m_err_o=1 for one cycle → IDLE.
- Granted master drops stb before ack (protocol violation): abort → IDLE, no ack or err.

RDATA:
- Granted m_ack_o=1; m_dat_o=s_dat_i for one cycle → IDLE.

Completion (ack or err):
- cnt cleared.
- lock flag := granted lock_i.
- If lock_i=0, ptr moves to the other master; if lock_i=1, ptr is unchanged.
- gnt cleared on entering IDLE.

Latency and sharing:
- Write: minimum 2 cycles, stb to ack.
- Read: 3 cycles, stb to ack with data.
- One access in flight at a time; no pipelining.
- Non-granted master: ack, err and dat_o held at 0.
- Simultaneous requests from IDLE: the locked master wins if any, else ptr. This guarantees alternation under contention when neither master is locked.
- A locked master that does not request in IDLE loses the lock flag, so the other master is served.

Decomposition:
- Shared package uart_arb_pkg: state encoding (IDLE, BUSY, RDATA), gnt one-hot constants (GNT_NONE, GNT_M0, GNT_M1), counter width 16.
- One natural sub-module: uart_arb_rr, the combinational 2-way priority picker. Inputs: req[1:0], ptr, lock_owner. Output: one-hot winner.

Test Plan:
- Single m0 write (adr=0, dat=0x41, s_ack tied high) → s_stb_o high in cycle 1, m0_ack_o pulse in cycle 1, gnt_o=01 then 00, ptr moves to m1.
- m1 read (adr=1); slave returns s_dat_i=0x36 the cycle after ack → m1_ack_o in cycle 2 with m1_dat_o=0x36; exactly one s_stb_o cycle.
- m0 and m1 both request 4 writes continuously, no lock → grants alternate m0, m1, m0, m1…; no master is starved.
- m1 holds lock_i=1 over 3 reads while m0 requests → m1 gets 3 consecutive grants; m0 granted immediately after m1 drops lock.
- Write with s_ack_i held low (TIMEOUT=16) → m0_err_o pulse on cycle 16 of BUSY, no ack, back to IDLE, cnt cleared.
- Assert sys_rst during BUSY → all outputs 0 that cycle, gnt_o=00, and a fresh request after release is granted normally.
